// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a valid/ready data-memory bus
// Optional: define LSU_MISALIGN_SPLIT_EN to run misaligned accesses as two word transactions.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           addr_in,
    input  logic [31:0]           write_data_in,
    input  logic [2:0]            funct3_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    output logic                  stall_out,
    output logic [31:0]           load_data_out,
    output logic                  misaligned_out,
    output logic                  bus_err_out,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_REQ2  = 3'd4;
    localparam logic [2:0] S_WAIT2 = 3'd5;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic                  split_q, split_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           wdata_hi_q, wdata_hi_d;
    logic [3:0]            wstrb_hi_q, wstrb_hi_d;
    logic [31:0]           lo_word_q, lo_word_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  bus_err_q, bus_err_d;

    logic        access, misaligned, take, timeout_hit;
    logic [1:0]  size;
    logic [31:0] al_wdata, sized_wd;
    logic [3:0]  al_wstrb, base_mask;
    logic [63:0] wide_wdata;
    logic [7:0]  wide_mask;
    logic [ADDR_WIDTH-1:0] word_addr;

    // Lane select plus extension; pair holds {next word, first word} so split loads reuse it.
    function automatic logic [31:0] fmt_load(input logic [63:0] pair, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b100:  fmt_load = {24'h0, sh[7:0]};
            3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            3'b101:  fmt_load = {16'h0, sh[15:0]};
            default: fmt_load = sh;
        endcase
    endfunction

    always_comb begin
        case (funct3_in)
            3'b000, 3'b100: size = 2'd0;
            3'b001, 3'b101: size = 2'd1;
            default:        size = 2'd2;
        endcase
        access     = mem_read_in | mem_write_in;
        misaligned = ((size == 2'd1) && addr_in[0]) || ((size == 2'd2) && (addr_in[1:0] != 2'b00));
        take       = access && (!misaligned || SPLIT_EN);

        case (size)
            2'd0: begin
                al_wdata  = {4{write_data_in[7:0]}};
                base_mask = 4'b0001;
                sized_wd  = {24'h0, write_data_in[7:0]};
            end
            2'd1: begin
                al_wdata  = {2{write_data_in[15:0]}};
                base_mask = 4'b0011;
                sized_wd  = {16'h0, write_data_in[15:0]};
            end
            default: begin
                al_wdata  = write_data_in;
                base_mask = 4'b1111;
                sized_wd  = write_data_in;
            end
        endcase
        al_wstrb   = base_mask << addr_in[1:0];
        wide_wdata = {32'h0, sized_wd} << {addr_in[1:0], 3'b000};
        wide_mask  = {4'h0, base_mask} << addr_in[1:0];
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wdata_hi_d  = wdata_hi_q;
        wstrb_hi_d  = wstrb_hi_q;
        lo_word_d   = lo_word_q;
        cnt_d       = '0;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    addr_d     = addr_in[ADDR_WIDTH-1:0];
                    funct3_d   = funct3_in;
                    we_d       = mem_write_in;
                    split_d    = misaligned;
                    wdata_d    = misaligned ? wide_wdata[31:0] : al_wdata;
                    wstrb_d    = !mem_write_in ? 4'h0 : (misaligned ? wide_mask[3:0] : al_wstrb);
                    wdata_hi_d = wide_wdata[63:32];
                    wstrb_hi_d = mem_write_in ? wide_mask[7:4] : 4'h0;
                    state_d    = S_REQ;
                end
            end
            S_REQ, S_REQ2: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_req_ready) begin
                    if (we_q)
                        state_d = (state_q == S_REQ && split_q) ? S_REQ2 : S_DONE;
                    else
                        state_d = (state_q == S_REQ) ? S_WAIT : S_WAIT2;
                end else if (timeout_hit) begin
                    state_d     = S_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end
            end
            S_WAIT, S_WAIT2: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rsp_valid) begin
                    if (state_q == S_WAIT && split_q) begin
                        lo_word_d = mem_rsp_data;
                        state_d   = S_REQ2;
                    end else begin
                        load_data_d = fmt_load((state_q == S_WAIT2) ? {mem_rsp_data, lo_word_q}
                                                                    : {32'h0, mem_rsp_data},
                                               addr_q[1:0], funct3_q);
                        state_d     = S_DONE;
                    end
                end else if (timeout_hit) begin
                    state_d     = S_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wdata_hi_q  <= '0;
            wstrb_hi_q  <= '0;
            lo_word_q   <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wdata_hi_q  <= wdata_hi_d;
            wstrb_hi_q  <= wstrb_hi_d;
            lo_word_q   <= lo_word_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign word_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_addr       = (state_q == S_REQ2) ? word_addr + ADDR_WIDTH'(4) : word_addr;
    assign mem_req_valid  = (state_q == S_REQ) || (state_q == S_REQ2);
    assign mem_we         = we_q;
    assign mem_wdata      = (state_q == S_REQ2) ? wdata_hi_q : wdata_q;
    assign mem_wstrb      = (state_q == S_REQ2) ? wstrb_hi_q : wstrb_q;
    assign load_data_out  = load_data_q;
    assign bus_err_out    = bus_err_q;
    // IDLE terms are gated by reset so every output reads 0 while reset is held.
    assign stall_out      = (reset_n && state_q == S_IDLE && take) ||
                            (state_q == S_REQ) || (state_q == S_WAIT) ||
                            (state_q == S_REQ2) || (state_q == S_WAIT2);
    assign misaligned_out = !SPLIT_EN && reset_n && (state_q == S_IDLE) && access && misaligned;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit; consumer side of the EX/MEM pipeline register.
- Takes the registered EX/MEM access fields: address (alu result), store data, funct3, mem_read, mem_write.
- Runs a valid/ready request plus response-valid transaction on the data-memory bus.
- Stalls the pipeline until the access completes, then presents formatted load data to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- ADDR_WIDTH, 32: bus address width; low ADDR_WIDTH bits of addr_in are used.

Ports:
- clock  in  1  single clock, all state on posedge
- reset_n  in  1  synchronous, active-low reset
- addr_in  in  32  access address (EX/MEM alu_result_out)
- write_data_in  in  32  store data, low-aligned (EX/MEM write_data_out)
- funct3_in  in  3  access size/sign (EX/MEM funct3_out)
- mem_read_in  in  1  load request
- mem_write_in  in  1  store request
- stall_out  out  1  hold PC/IF/ID/EX/MEM registers
- load_data_out  out  32  formatted load result, valid while state=DONE
- misaligned_out  out  1  one-cycle pulse on misaligned access
- bus_err_out  out  1  one-cycle pulse on timeout abort
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus request accepted
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00})
- mem_we  out  1  1=write
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read word

Behaviour:
- Access = mem_read_in|mem_write_in. If both are set, treat as a store.
- Size from funct3:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 011/110/111 are treated as word.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- FSM states IDLE, REQ, WAIT, DONE. Reset value: IDLE; all outputs 0; timeout counter 0.
- IDLE:
  - Aligned access: stall_out=1 (combinational), latch addr/wdata/funct3/we, go to REQ.
  - Misaligned access: no bus activity, stall_out=0, misaligned_out pulses in that cycle, stay in IDLE (see optional feature).
  - No access: stall_out=0.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until handshake.
  - stall_out=1.
  - On mem_req_valid&mem_req_ready: store goes to DONE, load goes to WAIT.
- WAIT:
  - stall_out=1, mem_req_valid=0.
  - On mem_rsp_valid: format the data, register it into load_data_out, go to DONE.
  - mem_rsp_valid seen in any other state is ignored.
- DONE:
  - stall_out=0 and load_data_out is valid for exactly this cycle; next state IDLE.
  - load_data_out holds its value until the next load completes.
  - DONE never restarts the same instruction; the pipeline advances on this cycle.
- Minimum latency with zero-wait bus:
  - Load: 3 stall cycles; load_data_out valid in cycle 4.
  - Store: 2 stall cycles.
- Store formatting:
  - SB: wdata={4{wd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{wd[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=wd, wstrb=4'b1111.
  - Loads drive wstrb=0, mem_we=0.
- Load formatting: select byte/halfword lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and clears in IDLE.
  - When the count reaches TIMEOUT_CYCLES (non-zero): go to DONE, bus_err_out pulses, load_data_out=0, mem_req_valid drops.
- reset_n low in any state: IDLE next cycle, mem_req_valid=0 next cycle; a late mem_rsp_valid is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned halfword/word accesses are performed as two bus transactions.
  - Lower word first, then addr+4, via extra states REQ2/WAIT2.
  - Bytes are merged per lane; stall is held throughout.
  - misaligned_out is never asserted.
- Undefined: the misaligned access is dropped with a misaligned_out pulse, as described above.

Test Plan:
- LW addr=0x100, ready=1, rsp_valid one cycle later with data 0xDEADBEEF -> stall high 3 cycles, load_data_out=0xDEADBEEF in DONE, mem_addr=0x100, wstrb=0.
- LB addr=0x103, rsp 0x80AABBCC -> load_data_out=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102 -> 0xFFFF80AA.
- SB addr=0x201, wd=0x123456EF -> mem_wdata=0xEFEFEFEF, wstrb=0010, mem_we=1, 2 stall cycles, no response awaited.
- LW addr=0x102 -> misaligned_out pulse, no mem_req_valid, stall_out=0 (macro undefined).
- LW with ready held 0 and TIMEOUT_CYCLES=8 -> bus_err_out pulse after 8 REQ cycles, load_data_out=0, then IDLE.
- reset_n low during WAIT, then rsp_valid arrives -> FSM in IDLE, stall_out=0, load_data_out unchanged (0).
